regfile_write_queue: RTL and testbench

- Producer side of the register file write port: collects writeback results from the ALU and the memory/load path and buffers them in a small FIFO.
- Issues at most one register write per cycle over write_enable / write_index / write_data.
- Reports combinational hazard flags for the two register file read indices, so decode can stall on a pending write.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_write_queue_fifo.sv | 66 ++++++
 rtl/regfile_write_queue.sv | 107 ++++++++++
 tb/tb_regfile_write_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file writeback path.
// Registers below WIDE_BASE are NARROW_W bits wide; the rest hold DATA_W bits.
package regfile_pkg;

   localparam int unsigned NUM_REGS  = 32;
   localparam int unsigned IDX_W     = 5;
   localparam int unsigned DATA_W    = 24;
   localparam int unsigned NARROW_W  = 16;
   localparam int unsigned WIDE_BASE = 28;

   typedef struct packed {
      logic [IDX_W-1:0]  index;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // Clear the bits a narrow register cannot hold so stale upper bits never reach it.
   function automatic logic [DATA_W-1:0] narrow_mask(input logic [IDX_W-1:0]  index,
                                                     input logic [DATA_W-1:0] data);
      logic [DATA_W-1:0] result;
      result = data;
      if (index < IDX_W'(WIDE_BASE)) begin
         result[DATA_W-1:NARROW_W] = '0;
      end
      return result;
   endfunction

endpackage

// File: rtl/regfile_write_queue_fifo.sv
// Dual-push, single-pop FIFO of writeback entries.
// Every slot is exposed with its valid bit so the hazard compare can see all queued writes.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_a,
   input  wb_entry_t                 entry_a,
   input  logic                      push_b,
   input  wb_entry_t                 entry_b,
   input  logic                      pop,
   output wb_entry_t                 head_entry,
   output wb_entry_t [DEPTH-1:0]     entries,
   output logic      [DEPTH-1:0]     valid,
   output logic      [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] slot_b;
   logic [PTR_W-1:0] tail_next;
   logic [CNT_W-1:0] count_next;
   logic             pop_ok;

   // Port A is older, so port B lands one slot behind it when both push.
   always_comb begin
      pop_ok     = pop && (count != '0);
      slot_b     = push_a ? (tail + PTR_W'(1)) : tail;
      tail_next  = tail + PTR_W'(push_a) + PTR_W'(push_b);
      count_next = count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop_ok);
      head_entry = entries[head];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         valid   <= '0;
         entries <= '0;
      end else begin
         if (pop_ok) begin
            valid[head] <= 1'b0;
            head        <= head + PTR_W'(1);
         end
         if (push_a) begin
            entries[tail] <= entry_a;
            valid[tail]   <= 1'b1;
         end
         if (push_b) begin
            entries[slot_b] <= entry_b;
            valid[slot_b]   <= 1'b1;
         end
         tail  <= tail_next;
         count <= count_next;
      end
   end

endmodule

// File: rtl/regfile_write_queue.sv
// Writeback queue feeding the register file write port from the ALU and load paths,
// with combinational read-after-write hazard flags for decode.
module regfile_write_queue
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [IDX_W-1:0]         alu_index,
   input  logic [DATA_W-1:0]        alu_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [IDX_W-1:0]         mem_index,
   input  logic [DATA_W-1:0]        mem_data,
   output logic                     write_enable,
   output logic [IDX_W-1:0]         write_index,
   output logic [DATA_W-1:0]        write_data,
   input  logic [IDX_W-1:0]         read_index_1,
   input  logic [IDX_W-1:0]         read_index_2,
   output logic                     pending_1,
   output logic                     pending_2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   wb_entry_t               entry_a;
   wb_entry_t               entry_b;
   wb_entry_t               head_entry;
   wb_entry_t [DEPTH-1:0]   entries;
   logic      [DEPTH-1:0]   valid;
   logic                    push_a;
   logic                    push_b;
   logic                    pop;

   // Readiness looks only at the registered count; a same-cycle pop earns no credit.
   always_comb begin
      alu_ready = (count <= CNT_W'(DEPTH - 1));
      if (alu_valid) begin
         mem_ready = (count <= CNT_W'(DEPTH - 2));
      end else begin
         mem_ready = (count <= CNT_W'(DEPTH - 1));
      end
      push_a = alu_valid && alu_ready;
      push_b = mem_valid && mem_ready;
      pop    = (count != '0);
   end

   always_comb begin
      entry_a       = '0;
      entry_b       = '0;
      entry_a.index = alu_index;
      entry_a.data  = narrow_mask(alu_index, alu_data);
      entry_b.index = mem_index;
      entry_b.data  = narrow_mask(mem_index, mem_data);
   end

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_a     (push_a),
      .entry_a    (entry_a),
      .push_b     (push_b),
      .entry_b    (entry_b),
      .pop        (pop),
      .head_entry (head_entry),
      .entries    (entries),
      .valid      (valid),
      .count      (count)
   );

   // Output stage: index/data hold their last value when nothing is popped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_enable <= 1'b0;
         write_index  <= '0;
         write_data   <= '0;
      end else begin
         write_enable <= pop;
         if (pop) begin
            write_index <= head_entry.index;
            write_data  <= head_entry.data;
         end
      end
   end

   // A write is pending while it sits in the queue or is on the write port this cycle.
   always_comb begin
      pending_1 = write_enable && (write_index == read_index_1);
      pending_2 = write_enable && (write_index == read_index_2);
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && (entries[i].index == read_index_1)) begin
            pending_1 = 1'b1;
         end
         if (valid[i] && (entries[i].index == read_index_2)) begin
            pending_2 = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue: expected writes are queued on acceptance
// and retired against the write port; occupancy is tracked by an independent model.
module tb_regfile_write_queue;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_index;
   logic [23:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_index;
   logic [23:0] mem_data;
   logic        write_enable;
   logic [4:0]  write_index;
   logic [23:0] write_data;
   logic [4:0]  read_index_1;
   logic [4:0]  read_index_2;
   logic        pending_1;
   logic        pending_2;
   logic [2:0]  count;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          model_cnt = 0;
   int          acc_n = 0;
   logic [28:0] sb[$];

   regfile_write_queue #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_index    (alu_index),
      .alu_data     (alu_data),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_index    (mem_index),
      .mem_data     (mem_data),
      .write_enable (write_enable),
      .write_index  (write_index),
      .write_data   (write_data),
      .read_index_1 (read_index_1),
      .read_index_2 (read_index_2),
      .pending_1    (pending_1),
      .pending_2    (pending_2),
      .count        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [28:0] make_exp(input logic [4:0] idx, input logic [23:0] d);
      logic [23:0] v;
      v = (idx < 5'd28) ? {8'h00, d[15:0]} : d;
      return {idx, v};
   endfunction

   // Occupancy model: pushes accepted this cycle minus one pop when non-empty.
   always @(posedge clk or posedge rst) begin
      if (rst) model_cnt = 0;
      else     model_cnt = model_cnt + acc_n - ((model_cnt != 0) ? 1 : 0);
   end

   // Retire expected writes as they appear on the write port.
   always @(posedge clk) begin
      logic [28:0] e;
      #1;
      if (!rst) begin
         check("count", 32'(count), 32'(model_cnt));
         if (write_enable) begin
            if (sb.size() == 0) begin
               check("stray_write", 32'(1), 32'(0));
            end else begin
               e = sb.pop_front();
               check("write_index", 32'(write_index), 32'(e[28:24]));
               check("write_data", 32'(write_data), 32'(e[23:0]));
            end
         end
      end
   end

   // Drive one cycle of pushes from a negedge; returns at the following negedge.
   task automatic push_cycle(input logic av, input logic [4:0] ai, input logic [23:0] ad,
                             input logic mv, input logic [4:0] mi, input logic [23:0] md);
      logic a_ok;
      logic m_ok;
      alu_valid = av; alu_index = ai; alu_data = ad;
      mem_valid = mv; mem_index = mi; mem_data = md;
      a_ok = (model_cnt <= 3);
      m_ok = av ? (model_cnt <= 2) : (model_cnt <= 3);
      #1;
      if (av) check("alu_ready", 32'(alu_ready), 32'(a_ok));
      if (mv) check("mem_ready", 32'(mem_ready), 32'(m_ok));
      acc_n = 0;
      if (av && a_ok) begin sb.push_back(make_exp(ai, ad)); acc_n++; end
      if (mv && m_ok) begin sb.push_back(make_exp(mi, md)); acc_n++; end
      @(negedge clk);
      acc_n = 0;
      alu_valid = 1'b0;
      mem_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && count == 3'd0 && !write_enable) break;
      end
      check("drain_sb_empty", 32'(sb.size()), 32'(0));
   endtask

   initial begin
      rst = 1'b1;
      alu_valid = 1'b0; alu_index = '0; alu_data = '0;
      mem_valid = 1'b0; mem_index = '0; mem_data = '0;
      read_index_1 = 5'd0; read_index_2 = 5'd31;
      repeat (2) @(negedge clk);
      check("rst_we", 32'(write_enable), 32'(0));
      check("rst_count", 32'(count), 32'(0));
      check("rst_pend1", 32'(pending_1), 32'(0));
      check("rst_pend2", 32'(pending_2), 32'(0));
      check("rst_widx", 32'(write_index), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      // Single narrow ALU write and its hazard window.
      read_index_1 = 5'd5;
      #1 check("single_pend_before", 32'(pending_1), 32'(0));
      push_cycle(1'b1, 5'd5, 24'hABCDEF, 1'b0, 5'd0, 24'h0);
      check("single_pend_queued", 32'(pending_1), 32'(1));
      check("single_we_early", 32'(write_enable), 32'(0));
      @(negedge clk);
      check("single_we", 32'(write_enable), 32'(1));
      check("single_data", 32'(write_data), 32'h00CDEF);
      check("single_pend_inflight", 32'(pending_1), 32'(1));
      check("single_pend2", 32'(pending_2), 32'(0));
      @(negedge clk);
      check("single_we_end", 32'(write_enable), 32'(0));
      check("single_pend_end", 32'(pending_1), 32'(0));
      check("single_data_hold", 32'(write_data), 32'h00CDEF);

      // Wide register keeps all bits.
      read_index_2 = 5'd30;
      push_cycle(1'b0, 5'd0, 24'h0, 1'b1, 5'd30, 24'h123456);
      check("wide_pend2", 32'(pending_2), 32'(1));
      @(negedge clk);
      check("wide_data", 32'(write_data), 32'h123456);
      drain();

      // Dual push to one index: ALU first, last write wins.
      push_cycle(1'b1, 5'd3, 24'h000001, 1'b1, 5'd3, 24'h000002);
      @(negedge clk);
      check("dual_we1", 32'(write_enable), 32'(1));
      check("dual_d1", 32'(write_data), 32'h000001);
      @(negedge clk);
      check("dual_we2", 32'(write_enable), 32'(1));
      check("dual_d2", 32'(write_data), 32'h000002);
      @(negedge clk);
      check("dual_we3", 32'(write_enable), 32'(0));
      drain();

      // Fill toward the boundary: at count 3 the ALU wins, mem is held off.
      push_cycle(1'b1, 5'd10, 24'h0A0A0A, 1'b1, 5'd11, 24'h0B0B0B);
      push_cycle(1'b1, 5'd12, 24'h0C0C0C, 1'b1, 5'd29, 24'hDDDDDD);
      check("fill_count3", 32'(count), 32'(3));
      push_cycle(1'b1, 5'd14, 24'h0E0E0E, 1'b1, 5'd15, 24'h0F0F0F);
      check("fill_hold_count", 32'(count), 32'(3));
      push_cycle(1'b0, 5'd0, 24'h0, 1'b1, 5'd15, 24'hFF0F0F);
      drain();

      // Back-to-back stream of single ALU pushes.
      for (int k = 0; k < 8; k++) begin
         push_cycle(1'b1, 5'(k), 24'(32'h110000 + k), 1'b0, 5'd0, 24'h0);
         if (k > 0) check("stream_we", 32'(write_enable), 32'(1));
         check("stream_cnt_le2", 32'(count <= 3'd2), 32'(1));
      end
      check("stream_we_last", 32'(write_enable), 32'(1));
      drain();

      // Reset with three writes queued discards them.
      push_cycle(1'b1, 5'd20, 24'h000014, 1'b1, 5'd21, 24'h000015);
      push_cycle(1'b1, 5'd22, 24'h000016, 1'b1, 5'd23, 24'h000017);
      read_index_1 = 5'd23;
      #1;
      check("pre_rst_count", 32'(count), 32'(3));
      check("pre_rst_pend1", 32'(pending_1), 32'(1));
      rst = 1'b1;
      sb.delete();
      #1;
      check("mid_rst_we", 32'(write_enable), 32'(0));
      check("mid_rst_count", 32'(count), 32'(0));
      check("mid_rst_pend1", 32'(pending_1), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_we", 32'(write_enable), 32'(0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
